// File: rtl/addsub_arb_pkg.sv
// Shared types and the round-robin pick helper for the arbitrated adder/subtractor.
package addsub_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int NBIT_DEF = 10;
    localparam int NREQ_DEF = 4;
    localparam int RR_MAX   = 16;
    localparam int RR_IDW   = 4;

    typedef struct packed {
        logic              found;
        logic [RR_IDW-1:0] idx;
    } rr_pick_t;

    // First set bit of valid at or above pointer, wrapping modulo nreq.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] valid,
                                         input logic [RR_IDW-1:0] pointer,
                                         input int                nreq);
        rr_pick_t          res;
        logic [RR_IDW-1:0] cand;
        res.found = 1'b0;
        res.idx   = {RR_IDW{1'b0}};
        for (int i = 0; i < RR_MAX; i++) begin
            cand = RR_IDW'((int'(pointer) + i) % nreq);
            if ((i < nreq) && !res.found && valid[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/addsub.sv
// NBIT adder/subtractor: sum_o = a_i + b_i, or a_i - b_i (two's complement) when sub_i is set.
module addsub
    import addsub_arb_pkg::*;
#(
    parameter int NBIT = NBIT_DEF
) (
    input  logic [NBIT-1:0] a_i,
    input  logic [NBIT-1:0] b_i,
    input  logic            sub_i,
    output logic [NBIT-1:0] sum_o
);

    // Subtract by inverting b and injecting the carry-in.
    always_comb begin
        sum_o = a_i + (b_i ^ {NBIT{sub_i}}) + NBIT'(sub_i);
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant and index of the first valid at/after the pointer.
module rr_arbiter
    import addsub_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  pointer,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any_grant
);

    logic [RR_MAX-1:0] valid_ext_s;
    logic [RR_IDW-1:0] ptr_ext_s;
    rr_pick_t          pick_s;

    // Widen to the helper's fixed width, pick, then decode the grant.
    always_comb begin
        valid_ext_s = RR_MAX'(valid);
        ptr_ext_s   = RR_IDW'(pointer);
        pick_s      = rr_pick(valid_ext_s, ptr_ext_s, NREQ);
        grant_idx   = IDW'(pick_s.idx);
        any_grant   = pick_s.found;
        grant       = {NREQ{1'b0}};
        if (pick_s.found) begin
            grant[grant_idx] = 1'b1;
        end else begin
            grant = {NREQ{1'b0}};
        end
    end

endmodule

// File: rtl/addsub_rr_arbiter.sv
// Shares one adder/subtractor among NREQ requesters via round-robin grant; one registered
// result slot returned on a valid/ready channel tagged with the requester index.
module addsub_rr_arbiter
    import addsub_arb_pkg::*;
#(
    parameter int NBIT = NBIT_DEF,
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      reqValid_i,
    output logic [NREQ-1:0]      reqReady_o,
    input  logic [NREQ*NBIT-1:0] reqFirst_i,
    input  logic [NREQ*NBIT-1:0] reqSecond_i,
    input  logic [NREQ-1:0]      reqSub_i,
    output logic                 resValid_o,
    input  logic                 resReady_i,
    output logic [NBIT-1:0]      resData_o,
    output logic [IDW-1:0]       resId_o
);

    state_t          state_r, state_s;
    logic [IDW-1:0]  ptr_r;
    logic [NBIT-1:0] res_data_r;
    logic [IDW-1:0]  res_id_r;
    logic            res_valid_r;

    logic [NREQ-1:0] grant_s;
    logic [IDW-1:0]  grant_idx_s;
    logic            any_grant_s;
    logic            slot_free_s;
    logic            accept_s;
    logic [NBIT-1:0] first_arr_s  [NREQ];
    logic [NBIT-1:0] second_arr_s [NREQ];
    logic [NBIT-1:0] first_s, second_s, sum_s;
    logic            sub_s;

    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign first_arr_s[k]  = reqFirst_i[k*NBIT +: NBIT];
        assign second_arr_s[k] = reqSecond_i[k*NBIT +: NBIT];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .valid     (reqValid_i),
        .pointer   (ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .any_grant (any_grant_s)
    );

    // The slot frees up in the same cycle the sink takes the held result.
    always_comb begin
        slot_free_s = (state_r == IDLE) || ((state_r == HOLD) && resReady_i);
        accept_s    = slot_free_s && any_grant_s && !rst_i;
        if (accept_s) begin
            reqReady_o = grant_s;
        end else begin
            reqReady_o = {NREQ{1'b0}};
        end
    end

    // Operand mux feeding the single shared arithmetic unit.
    always_comb begin
        first_s  = first_arr_s[grant_idx_s];
        second_s = second_arr_s[grant_idx_s];
        sub_s    = reqSub_i[grant_idx_s];
    end

    addsub #(
        .NBIT (NBIT)
    ) u_addsub (
        .a_i   (first_s),
        .b_i   (second_s),
        .sub_i (sub_s),
        .sum_o (sum_s)
    );

    // Next-state logic for the result slot.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = HOLD;
                else          state_s = IDLE;
            end
            HOLD: begin
                if (accept_s)        state_s = HOLD;
                else if (resReady_i) state_s = IDLE;
                else                 state_s = HOLD;
            end
            default: state_s = IDLE;
        endcase
    end

    // State, pointer and result registers; pointer moves only on accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            res_valid_r <= 1'b0;
            res_data_r  <= {NBIT{1'b0}};
            res_id_r    <= {IDW{1'b0}};
            ptr_r       <= {IDW{1'b0}};
        end else begin
            state_r     <= state_s;
            res_valid_r <= (state_s == HOLD);
            if (accept_s) begin
                res_data_r <= sum_s;
                res_id_r   <= grant_idx_s;
                if (grant_idx_s == IDW'(NREQ - 1)) ptr_r <= {IDW{1'b0}};
                else                               ptr_r <= grant_idx_s + IDW'(1);
            end
        end
    end

    assign resValid_o = res_valid_r;
    assign resData_o  = res_data_r;
    assign resId_o    = res_id_r;

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Scoreboard bench for addsub_rr_arbiter: directed scenarios then randomized traffic against a
// queue-based reference model of the arbitrated add/sub service.
module tb_addsub_rr_arbiter;

    localparam int NBIT = 10;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_i;
    logic [NREQ-1:0]      reqValid_i;
    logic [NREQ-1:0]      reqReady_o;
    logic [NREQ*NBIT-1:0] reqFirst_i;
    logic [NREQ*NBIT-1:0] reqSecond_i;
    logic [NREQ-1:0]      reqSub_i;
    logic                 resValid_o;
    logic                 resReady_i;
    logic [NBIT-1:0]      resData_o;
    logic [IDW-1:0]       resId_o;

    addsub_rr_arbiter #(.NBIT(NBIT), .NREQ(NREQ)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .reqValid_i  (reqValid_i),
        .reqReady_o  (reqReady_o),
        .reqFirst_i  (reqFirst_i),
        .reqSecond_i (reqSecond_i),
        .reqSub_i    (reqSub_i),
        .resValid_o  (resValid_o),
        .resReady_i  (resReady_i),
        .resData_o   (resData_o),
        .resId_o     (resId_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int data;
    } exp_t;

    exp_t            exp_q[$];
    int              tests = 0;
    int              fails = 0;

    logic [NREQ-1:0] v;
    logic [NBIT-1:0] a [NREQ];
    logic [NBIT-1:0] b [NREQ];
    logic            s [NREQ];
    logic            rr;
    logic            rst;

    bit              held_m = 1'b0;
    int              ptr_m  = 0;
    int              acc_m  = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: apply bench inputs, predict grant from the rules, update the model.
    task automatic step();
        int              idx;
        int              data;
        logic [NREQ-1:0] exp_ready;
        @(negedge clk);
        rst_i      = rst;
        resReady_i = rr;
        reqValid_i = v;
        for (int k = 0; k < NREQ; k++) begin
            reqFirst_i[k*NBIT +: NBIT]  = a[k];
            reqSecond_i[k*NBIT +: NBIT] = b[k];
            reqSub_i[k]                 = s[k];
        end
        #1;
        exp_ready = '0;
        acc_m     = -1;
        if (!rst && (!held_m || rr)) begin
            for (int i = 0; i < NREQ; i++) begin
                idx = (ptr_m + i) % NREQ;
                if (acc_m < 0 && v[idx]) acc_m = idx;
            end
        end
        if (acc_m >= 0) exp_ready[acc_m] = 1'b1;
        check("req_ready", 32'(reqReady_o), 32'(exp_ready));
        check("res_valid", 32'(resValid_o), 32'(held_m));
        if (rst) begin
            held_m = 1'b0;
            ptr_m  = 0;
            exp_q.delete();
        end else if (acc_m >= 0) begin
            if (s[acc_m]) data = (int'(a[acc_m]) + 1024 - int'(b[acc_m])) % 1024;
            else          data = (int'(a[acc_m]) + int'(b[acc_m])) % 1024;
            exp_q.push_back('{id: acc_m, data: data});
            held_m = 1'b1;
            ptr_m  = (acc_m + 1) % NREQ;
        end else if (rr) begin
            held_m = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: whenever a result is presented it must match the oldest expected entry.
    always @(negedge clk) begin
        #2;
        if (!rst_i && resValid_o) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_empty: result id %0d data %0d presented, none expected", resId_o, resData_o);
            end else begin
                check("sb_data", 32'(resData_o), 32'(exp_q[0].data));
                check("sb_id", 32'(resId_o), 32'(exp_q[0].id));
                if (resReady_i) void'(exp_q.pop_front());
            end
        end
    end

    task automatic rand_op(input int k);
        a[k] = 10'($urandom_range(0, 1023));
        b[k] = 10'($urandom_range(0, 1023));
        s[k] = 1'($urandom_range(0, 1));
    endtask

    initial begin
        rst_i = 1'b1; resReady_i = 1'b0; reqValid_i = '0;
        reqFirst_i = '0; reqSecond_i = '0; reqSub_i = '0;
        v = '0; rr = 1'b1; rst = 1'b1;
        for (int k = 0; k < NREQ; k++) begin a[k] = '0; b[k] = '0; s[k] = 1'b0; end

        step(); step();
        rst = 1'b0;
        check("reset_valid", 32'(resValid_o), 32'd0);
        check("reset_data", 32'(resData_o), 32'd0);
        check("reset_id", 32'(resId_o), 32'd0);

        // Single add 5 + 3 from requester 0.
        v = 4'b0001; a[0] = 10'd5; b[0] = 10'd3; s[0] = 1'b0;
        step();
        check("add_valid", 32'(resValid_o), 32'd1);
        check("add_data", 32'(resData_o), 32'd8);
        check("add_id", 32'(resId_o), 32'd0);
        v = '0;
        step();
        check("add_idle", 32'(resValid_o), 32'd0);

        // Wrap-around: 3 - 5 and 1000 + 100.
        v = 4'b0100; a[2] = 10'd3; b[2] = 10'd5; s[2] = 1'b1;
        step();
        check("sub_wrap", 32'(resData_o), 32'd1022);
        check("sub_id", 32'(resId_o), 32'd2);
        v = 4'b0010; a[1] = 10'd1000; b[1] = 10'd100; s[1] = 1'b0;
        step();
        check("add_wrap", 32'(resData_o), 32'd76);
        check("add_wrap_id", 32'(resId_o), 32'd1);
        v = '0;
        step();

        // Fairness from a fresh pointer: all requesters continuously valid.
        rst = 1'b1; step(); rst = 1'b0;
        for (int k = 0; k < NREQ; k++) rand_op(k);
        v = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step();
            check("fair_id", 32'(resId_o), 32'(i % NREQ));
            rand_op(acc_m);
        end

        // Backpressure for three cycles, then release accepts requester 0 in the same cycle.
        rr = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rr = 1'b1;
        step();
        check("release_id", 32'(resId_o), 32'd0);
        v = '0;
        step();

        // Pointer: serve 3, then with 1 and 3 pending, 1 wins first.
        v = 4'b1000; rand_op(3);
        step();
        v = 4'b1010; rand_op(1);
        step();
        check("ptr_first", 32'(resId_o), 32'd1);
        v = 4'b1000;
        step();
        check("ptr_second", 32'(resId_o), 32'd3);
        v = '0;
        step();

        // Reset while holding a stalled result.
        v = 4'b0001; rand_op(0);
        step();
        v = '0; rr = 1'b0; rst = 1'b1;
        step();
        check("rst_mid_valid", 32'(resValid_o), 32'd0);
        rst = 1'b0; rr = 1'b1; v = 4'b1111;
        step();
        check("rst_mid_first", 32'(resId_o), 32'd0);
        v = '0;
        step();

        // Randomized traffic with backpressure, early drops and occasional reset.
        for (int c = 0; c < 3000; c++) begin
            rr  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < NREQ; k++) begin
                if (!v[k] && $urandom_range(0, 2) == 0) begin
                    v[k] = 1'b1;
                    rand_op(k);
                end else if (v[k] && $urandom_range(0, 31) == 0) begin
                    v[k] = 1'b0;
                end
            end
            step();
            if (acc_m >= 0) v[acc_m] = 1'b0;
        end

        // Drain everything outstanding.
        v = '0; rr = 1'b1; rst = 1'b0;
        step(); step(); step();
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
